// File: rtl/plru_pkg.sv
`default_nettype none
// ============================================================================
// plru_pkg : shared types and node-index helpers for the tree pseudo-LRU unit
// Revision : 1.0
// ============================================================================
package plru_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } plru_state_e;

    function automatic int node_parent(input int node);
        return (node - 1) / 2;
    endfunction

    function automatic int node_left(input int node);
        return 2 * node + 1;
    endfunction

    function automatic int leaf_to_way(input int leaf, input int ways);
        return leaf - (ways - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/plru_tree_logic.sv
`default_nettype none
// ============================================================================
// plru_tree_logic : combinational touch update and victim walk for one set
// Revision : 1.0
// ============================================================================
module plru_tree_logic
    import plru_pkg::*;
#(
    parameter int WAYS  = 8,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  touch_bits,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAYS-2:0]  touched_bits,
    input  logic [WAYS-2:0]  lookup_bits,
    input  logic [WAYS-1:0]  valid_mask,
    output logic [WAY_W-1:0] victim_way
);

    logic [WAY_W-1:0] w_tree_way;
    logic [WAY_W-1:0] w_inv_way;

    // A node at depth d covers 2**(WAY_W-d) ways; the touched way is on its
    // path when the way's upper bits equal the node's position in the level.
    for (genvar d = 0; d < WAY_W; d++) begin : g_level
        for (genvar p = 0; p < (1 << d); p++) begin : g_node
            localparam int NODE = (1 << d) - 1 + p;
            localparam int SPAN = WAY_W - d;
            assign touched_bits[NODE] = ((touch_way >> SPAN) == WAY_W'(p)) ?
                                        ~touch_way[SPAN-1] : touch_bits[NODE];
        end
    end

    always_comb begin : p_walk
        int              w_node;
        logic [WAYS-2:0] w_sh;
        w_node = 0;
        w_sh   = '0;
        for (int d = 0; d < WAY_W; d++) begin
            w_sh   = lookup_bits >> w_node;
            w_node = node_left(w_node) + int'(w_sh[0]);
        end
        w_tree_way = WAY_W'(leaf_to_way(w_node, WAYS));
    end

    always_comb begin : p_invalid
        logic [WAYS-1:0] w_m;
        w_inv_way = '0;
        w_m       = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            w_m = valid_mask >> i;
            if (!w_m[0]) begin
                w_inv_way = WAY_W'(i);
            end
        end
    end

    assign victim_way = (&valid_mask) ? w_tree_way : w_inv_way;

endmodule
`default_nettype wire

// File: rtl/plru_tree_nway.sv
`default_nettype none
// ============================================================================
// plru_tree_nway : per-set tree pseudo-LRU with invalid-first victims,
//                  touch/lookup forwarding and a sequential flush sweep
// Revision : 1.0
// ============================================================================
module plru_tree_nway
    import plru_pkg::*;
#(
    parameter int WAYS  = 8,
    parameter int SETS  = 8,
    parameter int WAY_W = $clog2(WAYS),
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             touch_valid,
    input  logic [IDX_W-1:0] touch_index,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             victim_req,
    input  logic [IDX_W-1:0] victim_index,
    input  logic [WAYS-1:0]  valid_mask,
    input  logic             flush_req,
    output logic             ready,
    output logic             victim_valid,
    output logic [WAY_W-1:0] victim_way
);

    logic [WAYS-2:0]  r_tree [SETS];
    plru_state_e      r_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_victim_valid;
    logic [WAY_W-1:0] r_victim_way;

    logic             w_idle;
    logic             w_touch_acc;
    logic             w_victim_acc;
    logic [WAYS-2:0]  w_touched;
    logic [WAYS-2:0]  w_lookup;
    logic [WAY_W-1:0] w_victim_sel;

    assign w_idle       = (r_state == IDLE);
    // A flush in the same cycle drops the touch but still answers the lookup.
    assign w_touch_acc  = w_idle & touch_valid & ~flush_req;
    assign w_victim_acc = w_idle & victim_req;
    assign w_lookup     = (w_touch_acc && (touch_index == victim_index)) ?
                          w_touched : r_tree[victim_index];

    plru_tree_logic #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_logic (
        .touch_bits   (r_tree[touch_index]),
        .touch_way    (touch_way),
        .touched_bits (w_touched),
        .lookup_bits  (w_lookup),
        .valid_mask   (valid_mask),
        .victim_way   (w_victim_sel)
    );

    for (genvar s = 0; s < SETS; s++) begin : g_set
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_tree[s] <= '0;
            end else if (r_state == FLUSH) begin
                if (r_cnt == IDX_W'(s)) begin
                    r_tree[s] <= '0;
                end
            end else if (w_touch_acc && (touch_index == IDX_W'(s))) begin
                r_tree[s] <= w_touched;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush_req) begin
                        r_state <= FLUSH;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == IDX_W'(SETS - 1)) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_victim_valid <= 1'b0;
            r_victim_way   <= '0;
        end else begin
            r_victim_valid <= w_victim_acc;
            if (w_victim_acc) begin
                r_victim_way <= w_victim_sel;
            end
        end
    end

    assign ready        = r_ready;
    assign victim_valid = r_victim_valid;
    assign victim_way   = r_victim_way;

endmodule
`default_nettype wire

// File: tb/tb_plru_tree_nway.sv
`default_nettype none
// ============================================================================
// tb_plru_tree_nway : directed table plus random traffic on a 4-way and an
//                     8-way instance sharing one input stream
// Revision : 1.0
// ============================================================================
module tb_plru_tree_nway;

    logic       clk;
    logic       rst_n;
    logic       touch_valid;
    logic [2:0] touch_index;
    logic [2:0] touch_way;
    logic       victim_req;
    logic [2:0] victim_index;
    logic [7:0] valid_mask;
    logic       flush_req;

    logic       ready_a, vv_a;
    logic [1:0] way_a;
    logic       ready_b, vv_b;
    logic [2:0] way_b;

    plru_tree_nway #(.WAYS(4), .SETS(8)) u_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .touch_valid  (touch_valid),
        .touch_index  (touch_index),
        .touch_way    (touch_way[1:0]),
        .victim_req   (victim_req),
        .victim_index (victim_index),
        .valid_mask   (valid_mask[3:0]),
        .flush_req    (flush_req),
        .ready        (ready_a),
        .victim_valid (vv_a),
        .victim_way   (way_a)
    );

    plru_tree_nway #(.WAYS(8), .SETS(8)) u_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .touch_valid  (touch_valid),
        .touch_index  (touch_index),
        .touch_way    (touch_way),
        .victim_req   (victim_req),
        .victim_index (victim_index),
        .valid_mask   (valid_mask),
        .flush_req    (flush_req),
        .ready        (ready_b),
        .victim_valid (vv_b),
        .victim_way   (way_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: per set, the node bits of the tree, indexed [dut][set][node].
    int mt [2][8][7];
    int busy;
    int last_w4, last_w8;

    typedef struct {
        logic       tv;
        int         ti;
        int         tw;
        logic       vr;
        int         vi;
        logic [7:0] vm;
        logic       fr;
        logic       er;
        logic       ev;
        int         e4;
        int         e8;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nways(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 8; s++)
                for (int n = 0; n < 7; n++)
                    mt[k][s][n] = 0;
    endtask

    // Walk the way range by halving; each node on the path points at the half
    // that does not contain the touched way.
    task automatic model_touch(input int k, input int s, input int w);
        int lo, hi, n, mid;
        lo = 0; hi = nways(k); n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w < mid) begin
                mt[k][s][n] = 1; n = 2 * n + 1; hi = mid;
            end else begin
                mt[k][s][n] = 0; n = 2 * n + 2; lo = mid;
            end
        end
    endtask

    function automatic int model_victim(input int k, input int s, input logic [7:0] m);
        int lo, hi, n, mid;
        for (int i = 0; i < nways(k); i++)
            if (!m[i]) return i;
        lo = 0; hi = nways(k); n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mt[k][s][n] == 0) begin
                n = 2 * n + 1; hi = mid;
            end else begin
                n = 2 * n + 2; lo = mid;
            end
        end
        return lo;
    endfunction

    task automatic cycle(input logic tv, input int ti, input int tw, input logic vr,
                         input int vi, input logic [7:0] vm, input logic fr);
        logic ev;
        ev = 1'b0;
        touch_valid  = tv;
        touch_index  = 3'(ti);
        touch_way    = 3'(tw);
        victim_req   = vr;
        victim_index = 3'(vi);
        valid_mask   = vm;
        flush_req    = fr;
        if (busy == 0) begin
            if (tv && !fr) begin
                model_touch(0, ti, tw % 4);
                model_touch(1, ti, tw);
            end
            if (vr) begin
                ev      = 1'b1;
                last_w4 = model_victim(0, vi, vm);
                last_w8 = model_victim(1, vi, vm);
            end
            if (fr) begin
                model_clear();
                busy = 8;
            end
        end else begin
            busy--;
        end
        @(posedge clk);
        #1;
        chk("ready_a", ready_a, (busy == 0));
        chk("ready_b", ready_b, (busy == 0));
        chk("vvalid_a", vv_a, ev);
        chk("vvalid_b", vv_b, ev);
        chk("vway_a", way_a, last_w4);
        chk("vway_b", way_b, last_w8);
    endtask

    task automatic add(input logic tv, input int ti, input int tw, input logic vr,
                       input int vi, input logic [7:0] vm, input logic fr,
                       input logic er, input logic ev, input int e4, input int e8);
        vec_t v;
        v.tv = tv; v.ti = ti; v.tw = tw; v.vr = vr; v.vi = vi; v.vm = vm; v.fr = fr;
        v.er = er; v.ev = ev; v.e4 = e4; v.e8 = e8;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        touch_valid = 1'b0; touch_index = '0; touch_way = '0;
        victim_req = 1'b0; victim_index = '0; valid_mask = 8'hFF; flush_req = 1'b0;
        model_clear();
        busy = 0; last_w4 = 0; last_w8 = 0;

        // Directed vectors with hand-derived expectations.
        add(0, 0, 0, 1, 0, 8'hFF, 0, 1, 1, 0, 0);
        add(1, 3, 0, 0, 0, 8'hFF, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 3, 8'hFF, 0, 1, 1, 2, 4);
        add(1, 3, 2, 0, 0, 8'hFF, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 3, 8'hFF, 0, 1, 1, 1, 4);
        add(0, 0, 0, 1, 2, 8'hFF, 0, 1, 1, 0, 0);
        for (int w = 0; w < 8; w++) add(1, 5, w, 0, 0, 8'hFF, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 5, 8'hFF, 0, 1, 1, 0, 0);
        add(0, 0, 0, 1, 5, 8'b1111_0101, 0, 1, 1, 1, 1);
        add(1, 0, 0, 1, 0, 8'hFF, 0, 1, 1, 2, 4);
        add(1, 3, 0, 1, 3, 8'hFF, 1, 0, 1, 1, 4);
        for (int i = 0; i < 8; i++) add(1, i, 3, 1, i, 8'hFF, 1, (i == 7), 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 1, i, 8'hFF, 0, 1, 1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", ready_a, 1);
        chk("rst_ready_b", ready_b, 1);
        chk("rst_vvalid_b", vv_b, 0);
        chk("rst_vway_b", way_b, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].tv, tbl[i].ti, tbl[i].tw, tbl[i].vr, tbl[i].vi, tbl[i].vm, tbl[i].fr);
            chk($sformatf("tbl%0d_ready", i), ready_b, tbl[i].er);
            chk($sformatf("tbl%0d_vvalid", i), vv_a, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_way4", i), way_a, tbl[i].e4);
                chk($sformatf("tbl%0d_way8", i), way_b, tbl[i].e8);
            end
        end

        // Reset asserted in the fourth flush cycle aborts the sweep.
        for (int s = 0; s < 8; s++) cycle(1, s, 7, 0, 0, 8'hFF, 0);
        cycle(0, 0, 0, 0, 0, 8'hFF, 1);
        repeat (3) cycle(0, 0, 0, 0, 0, 8'hFF, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midflush_ready_a", ready_a, 1);
        chk("midflush_ready_b", ready_b, 1);
        chk("midflush_vway_b", way_b, 0);
        model_clear();
        busy = 0; last_w4 = 0; last_w8 = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 0; s < 8; s++) begin
            cycle(0, 0, 0, 1, s, 8'hFF, 0);
            chk($sformatf("postrst_set%0d_way8", s), way_b, 0);
        end
        // A fresh flush after the aborted one must still last exactly 8 cycles.
        cycle(1, 2, 5, 0, 0, 8'hFF, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 0, 0, 8'hFF, 0);
            chk($sformatf("reflush_ready%0d", i), ready_b, (i == 7));
        end

        // Random traffic against the model, biased toward same-set collisions.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] m;
            int ti, vi;
            m  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            ti = $urandom_range(0, 7);
            vi = ($urandom_range(0, 1) == 0) ? ti : $urandom_range(0, 7);
            cycle(1'($urandom), ti, $urandom_range(0, 7), 1'($urandom), vi, m,
                  ($urandom_range(0, 59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
